// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and constants for the two-port memory arbiter:
//               transaction state encoding, default bus widths and the
//               requester port identifiers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  // Requester identifiers; also the encoding of the round-robin 'last' bit.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of the two requester handshakes, their responses and
//               the memory control bus.
//               slave  : arbiter side (accepts requests, drives memory).
//               master : environment side (requesters + memory block).
//               rsp0_err / rsp1_err exist only with MEMARB_PROT_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic              req0_we,    req1_we;
  logic [ADDR_W-1:0] req0_addr,  req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
`ifdef MEMARB_PROT_EN
  logic              rsp0_err,   rsp1_err;
`endif
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read_write;
  logic              mem_en;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
`ifdef MEMARB_PROT_EN
    output rsp0_err, rsp1_err,
`endif
    input  req0_valid, req1_valid, req0_we, req1_we,
    input  req0_addr, req1_addr, req0_wdata, req1_wdata,
    input  mem_data_out,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
    output mem_addr, mem_data_in, mem_read_write, mem_en
  );

  modport master (
`ifdef MEMARB_PROT_EN
    input  rsp0_err, rsp1_err,
`endif
    output req0_valid, req1_valid, req0_we, req1_we,
    output req0_addr, req1_addr, req0_wdata, req1_wdata,
    output mem_data_out,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
    input  mem_addr, mem_data_in, mem_read_write, mem_en
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Combinational two-requester round-robin grant.
//               i_valid0/i_valid1 : requests present
//               i_last            : port served most recently
//               o_grant_valid     : at least one request present
//               o_grant           : granted port (0/1)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last,
  output logic o_grant_valid,
  output logic o_grant
);

  always_comb begin
    o_grant_valid = i_valid0 | i_valid1;
    o_grant       = 1'b0;
    if (i_valid0 && i_valid1) begin
      // Contention: the port not served last time wins.
      o_grant = ~i_last;
    end else if (i_valid1) begin
      o_grant = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin controller sharing one memory between the fetch
//               port (0) and the load/store port (1). One request at a time,
//               fixed 4-cycle transaction IDLE -> ISSUE -> WAIT -> RESP.
//               clk, rst_n : clock, synchronous active-low reset
//               bus        : mem_arbiter_if.slave (requests, responses,
//                            memory control)
//               Optional MEMARB_PROT_EN: writes at addr >= PROT_BASE are
//               suppressed and answered with rspN_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] PROT_BASE = ADDR_W'(24)
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  state_t            r_state, w_state_nxt;
  logic              r_last;
  logic              r_port;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;
  logic              w_grant_valid, w_grant;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_blk;

  rr_arb2 u_rr_arb2 (
    .i_valid0      (bus.req0_valid),
    .i_valid1      (bus.req1_valid),
    .i_last        (r_last),
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  assign w_sel_we    = w_grant ? bus.req1_we    : bus.req0_we;
  assign w_sel_addr  = w_grant ? bus.req1_addr  : bus.req0_addr;
  assign w_sel_wdata = w_grant ? bus.req1_wdata : bus.req0_wdata;

`ifdef MEMARB_PROT_EN
  logic r_blk;
  assign w_blk = r_blk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blk <= 1'b0;
    end else if (r_state == ST_IDLE && w_grant_valid) begin
      r_blk <= w_sel_we && (w_sel_addr >= PROT_BASE);
    end
  end
`else
  logic w_unused_prot;
  assign w_blk         = 1'b0;
  assign w_unused_prot = ^PROT_BASE;
`endif

  // State register and transaction registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_last   <= PORT_LSU;   // so the fetch port wins the first contention
      r_port   <= PORT_FETCH;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_grant_valid) begin
        r_port  <= w_grant;
        r_last  <= w_grant;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      // Memory data is valid the cycle after the strobe, i.e. in WAIT.
      // Each port keeps its last response data until its next response.
      if (r_state == ST_WAIT) begin
        if (r_port == PORT_LSU) begin
          r_rdata1 <= r_we ? '0 : bus.mem_data_out;
        end else begin
          r_rdata0 <= r_we ? '0 : bus.mem_data_out;
        end
      end
    end
  end

  assign bus.rsp0_rdata = r_rdata0;
  assign bus.rsp1_rdata = r_rdata1;

  // Next state and decoded outputs.
  always_comb begin
    w_state_nxt        = r_state;
    bus.req0_ready     = 1'b0;
    bus.req1_ready     = 1'b0;
    bus.rsp0_valid     = 1'b0;
    bus.rsp1_valid     = 1'b0;
    bus.mem_en         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_data_in    = '0;
    bus.mem_read_write = 1'b0;
`ifdef MEMARB_PROT_EN
    bus.rsp0_err       = 1'b0;
    bus.rsp1_err       = 1'b0;
`endif
    // Memory bus holds the latched transaction from ISSUE through RESP.
    if (r_state != ST_IDLE) begin
      bus.mem_addr       = r_addr;
      bus.mem_data_in    = r_wdata;
      bus.mem_read_write = r_we;
    end
    case (r_state)
      ST_IDLE: begin
        bus.req0_ready = w_grant_valid && (w_grant == PORT_FETCH);
        bus.req1_ready = w_grant_valid && (w_grant == PORT_LSU);
        if (w_grant_valid) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.mem_en  = ~w_blk;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp0_valid = (r_port == PORT_FETCH);
        bus.rsp1_valid = (r_port == PORT_LSU);
`ifdef MEMARB_PROT_EN
        bus.rsp0_err   = w_blk && (r_port == PORT_FETCH);
        bus.rsp1_err   = w_blk && (r_port == PORT_LSU);
`endif
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a memory stub, a
//               transaction-level reference model compared every cycle, and
//               directed scenarios with literal expectations.
//               Honours MEMARB_PROT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(5), .DATA_W(8), .PROT_BASE(5'd24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return (i == 31) ? 8'h3C : 8'(i * 13 + 7);
  endfunction

  // ---------------- memory block stub ----------------
  logic [7:0] stub_mem [32];
  logic [7:0] stub_dout = 8'h00;
  assign bus.mem_data_out = stub_dout;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_read_write) stub_mem[bus.mem_addr] <= bus.mem_data_in;
      else                    stub_dout <= stub_mem[bus.mem_addr];
    end
  end

  // ---------------- transaction-level reference model ----------------
  // A transaction is described by its age in cycles since the handshake:
  // age 1 = memory strobe, age 3 = response pulse, then free again.
  bit         m_act  = 1'b0;
  int         m_age  = 0;
  int         m_port = 0;
  bit         m_last = 1'b1;
  bit         m_we, m_blk;
  logic [4:0] m_addr;
  logic [7:0] m_wdata, m_val;
  logic [7:0] m_mem [32];
  logic [7:0] m_rd  [2] = '{8'h00, 8'h00};
  int         ncyc  = 0;
  int         hs_port[$];
  int         hs_cyc[$];
  int         en_log[$];
  int         rsp_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    logic       g_valid, g;
    logic       e_rdy0, e_rdy1, e_en, e_rw, e_v0, e_v1, e_err;
    logic [4:0] e_addr;
    logic [7:0] e_din;
    ncyc++;
    e_rdy0 = 0; e_rdy1 = 0; e_en = 0; e_rw = 0; e_v0 = 0; e_v1 = 0; e_err = 0;
    e_addr = '0; e_din = '0;
    g_valid = bus.req0_valid | bus.req1_valid;
    g       = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
    if (!m_act) begin
      e_rdy0 = g_valid && !g;
      e_rdy1 = g_valid && g;
    end else begin
      e_addr = m_addr;
      e_din  = m_wdata;
      e_rw   = m_we;
      e_en   = (m_age == 1) && !m_blk;
      if (m_age == 3) begin
        if (m_port == 0) e_v0 = 1'b1; else e_v1 = 1'b1;
        e_err = m_blk;
      end
    end

    if (rst_n) begin
      chk("req0_ready", bus.req0_ready, e_rdy0);
      chk("req1_ready", bus.req1_ready, e_rdy1);
    end
    chk("mem_en",         bus.mem_en,         e_en);
    chk("mem_addr",       bus.mem_addr,       e_addr);
    chk("mem_data_in",    bus.mem_data_in,    e_din);
    chk("mem_read_write", bus.mem_read_write, e_rw);
    chk("rsp0_valid",     bus.rsp0_valid,     e_v0);
    chk("rsp1_valid",     bus.rsp1_valid,     e_v1);
    chk("rsp0_rdata",     bus.rsp0_rdata,     m_rd[0]);
    chk("rsp1_rdata",     bus.rsp1_rdata,     m_rd[1]);
`ifdef MEMARB_PROT_EN
    chk("rsp0_err", bus.rsp0_err, e_err && (m_port == 0));
    chk("rsp1_err", bus.rsp1_err, e_err && (m_port == 1));
`endif

    if (bus.mem_en === 1'b1) en_log.push_back(int'(bus.mem_read_write));
    if (bus.rsp0_valid === 1'b1) rsp_cnt[0]++;
    if (bus.rsp1_valid === 1'b1) rsp_cnt[1]++;

    // Advance the model across the coming rising edge.
    if (!rst_n) begin
      m_act  = 1'b0;
      m_last = 1'b1;
      m_rd[0] = 8'h00;
      m_rd[1] = 8'h00;
    end else if (!m_act) begin
      if (g_valid) begin
        hs_port.push_back(int'(g));
        hs_cyc.push_back(ncyc);
        m_act   = 1'b1;
        m_age   = 1;
        m_port  = int'(g);
        m_we    = g ? bus.req1_we    : bus.req0_we;
        m_addr  = g ? bus.req1_addr  : bus.req0_addr;
        m_wdata = g ? bus.req1_wdata : bus.req0_wdata;
        m_last  = g;
`ifdef MEMARB_PROT_EN
        m_blk   = m_we && (m_addr >= 5'd24);
`else
        m_blk   = 1'b0;
`endif
      end
    end else begin
      if (m_age == 1) begin
        m_val = 8'h00;
        if (!m_we) m_val = m_mem[m_addr];
        else if (!m_blk) m_mem[m_addr] = m_wdata;
      end
      if (m_age == 2) m_rd[m_port] = m_val;
      if (m_age == 3) m_act = 1'b0;
      else m_age++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic v, input logic we,
                         input logic [4:0] addr, input logic [7:0] wd);
    if (port == 0) begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = addr; bus.req0_wdata = wd;
    end else begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = addr; bus.req1_wdata = wd;
    end
  endtask

  // Raise a request, wait for ready, complete the handshake edge, drop valid.
  task automatic start_req(input int port, input logic we,
                           input logic [4:0] addr, input logic [7:0] wd);
    bit got = 1'b0;
    set_req(port, 1'b1, we, addr, wd);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((port == 0) ? bus.req0_ready : bus.req1_ready) got = 1'b1;
    end
    chk("handshake_timeout", got, 1);
    @(posedge clk);
    #1;
    set_req(port, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  // Count cycles after the handshake edge until the response pulse.
  task automatic wait_rsp(input int port, output int lat, output logic [7:0] rd,
                          output logic err);
    bit got = 1'b0;
    lat = 0; rd = 8'h00; err = 1'b0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if ((port == 0) ? bus.rsp0_valid : bus.rsp1_valid) begin
        got = 1'b1;
        lat = i;
        rd  = (port == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
`ifdef MEMARB_PROT_EN
        err = (port == 0) ? bus.rsp0_err : bus.rsp1_err;
`endif
      end
    end
    chk("response_timeout", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int         lat, c0, c1;
    logic [7:0] rd;
    logic       err;
    for (int i = 0; i < 32; i++) begin
      stub_mem[i] = init_val(i);
      m_mem[i]    = init_val(i);
    end
    set_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 5'd0, 8'h00);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("reset_mem_en",     bus.mem_en,     0);
    chk("reset_mem_addr",   bus.mem_addr,   0);
    chk("reset_rsp0_rdata", bus.rsp0_rdata, 0);

    // Port 0 write then read back address 3.
    en_log.delete();
    start_req(0, 1'b1, 5'd3, 8'hA5);
    wait_rsp(0, lat, rd, err);
    chk("wr_rdata_zero", rd, 8'h00);
    start_req(0, 1'b0, 5'd3, 8'h00);
    wait_rsp(0, lat, rd, err);
    chk("rd_latency", lat, 3);
    chk("rd_data", rd, 8'hA5);
    tick();
    chk("en_pulses", en_log.size(), 2);
    if (en_log.size() == 2) begin
      chk("en_rw_first",  en_log[0], 1);
      chk("en_rw_second", en_log[1], 0);
    end

    // Both ports requesting continuously after reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hs_port.delete(); hs_cyc.delete();
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    set_req(0, 1'b1, 1'b0, 5'd7, 8'h00);
    set_req(1, 1'b1, 1'b0, 5'd9, 8'h00);
    repeat (14) tick();
    set_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 5'd0, 8'h00);
    repeat (4) tick();
    chk("rr_hs_count", hs_port.size(), 4);
    if (hs_port.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_grant_order", hs_port[i], i % 2);
        if (i > 0) chk("rr_hs_spacing", hs_cyc[i] - hs_cyc[i-1], 4);
      end
    end
    chk("rr_rsp0_count", rsp_cnt[0], 2);
    chk("rr_rsp1_count", rsp_cnt[1], 2);

    // Port 1 read of the top address.
    c0 = rsp_cnt[0];
    start_req(1, 1'b0, 5'd31, 8'h00);
    wait_rsp(1, lat, rd, err);
    chk("p1_latency", lat, 3);
    chk("p1_data", rd, 8'h3C);
    chk("p1_no_rsp0", rsp_cnt[0], c0);
    tick();

    // Reset while the transaction is in WAIT.
    c0 = rsp_cnt[0];
    start_req(0, 1'b0, 5'd10, 8'h00);   // now in ISSUE
    tick();                             // now in WAIT
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_mem_en",     bus.mem_en,     0);
    chk("abort_mem_addr",   bus.mem_addr,   0);
    chk("abort_rsp0_valid", bus.rsp0_valid, 0);
    chk("abort_rsp0_rdata", bus.rsp0_rdata, 0);
    repeat (3) tick();
    chk("abort_no_response", rsp_cnt[0], c0);
    hs_port.delete();
    set_req(0, 1'b1, 1'b0, 5'd1, 8'h00);
    set_req(1, 1'b1, 1'b0, 5'd2, 8'h00);
    tick();
    set_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
    set_req(1, 1'b0, 1'b0, 5'd0, 8'h00);
    repeat (4) tick();
    chk("post_reset_hs_count", hs_port.size(), 1);
    if (hs_port.size() >= 1) chk("post_reset_grant", hs_port[0], 0);

    // Port 0 pulses valid while port 1 owns the memory.
    hs_port.delete();
    c0 = rsp_cnt[0];
    c1 = rsp_cnt[1];
    start_req(1, 1'b0, 5'd12, 8'h00);
    set_req(0, 1'b1, 1'b1, 5'd4, 8'h77);
    tick();
    set_req(0, 1'b0, 1'b0, 5'd0, 8'h00);
    repeat (5) tick();
    chk("pulse_hs_count", hs_port.size(), 1);
    chk("pulse_no_rsp0", rsp_cnt[0], c0);
    chk("pulse_rsp1", rsp_cnt[1], c1 + 1);

`ifdef MEMARB_PROT_EN
    // Protected write suppressed, boundary write just below allowed.
    en_log.delete();
    start_req(0, 1'b1, 5'd24, 8'h5A);
    wait_rsp(0, lat, rd, err);
    chk("prot_err", err, 1);
    chk("prot_rdata", rd, 8'h00);
    chk("prot_no_strobe", en_log.size(), 0);
    tick();
    start_req(0, 1'b1, 5'd23, 8'h66);
    wait_rsp(0, lat, rd, err);
    chk("unprot_err", err, 0);
    chk("unprot_strobe", en_log.size(), 1);
    tick();
    start_req(1, 1'b0, 5'd24, 8'h00);
    wait_rsp(1, lat, rd, err);
    chk("prot_read_ok", rd, 8'h3F);
    chk("prot_read_err", err, 0);
    tick();
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
